serial_subtractor_n: RTL and testbench
======================================

// Module: serial_subtractor_n
//
// PURPOSE
// Bit-serial N-bit subtractor: computes diff = a - b - b_in, one bit per clock, LSB first,
// through a single full-subtractor cell. It is the subtract-side counterpart of the ripple
// adder_n datapath and is used where area matters more than latency. Operands are accepted
// on a valid/ready handshake, and results are returned on a valid/ready handshake.
//
// PARAMETERS
// N   8   operand/result width in bits; legal range 1..32
//
// PORTS
// clk        in   1  system clock; all state updates on posedge
// rst        in   1  reset, asynchronous, active-high
// ena        in   1  clock enable; when low, all state holds (handshakes are also frozen)
// in_valid   in   1  a, b, b_in are valid
// in_ready   out  1  block can accept operands
// a          in   N  minuend
// b          in   N  subtrahend
// b_in       in   1  borrow in
// out_valid  out  1  diff and b_out are valid
// out_ready  in   1  consumer accepts the result
// diff       out  N  (a - b - b_in) mod 2^N
// b_out      out  1  borrow out; 1 iff a < b + b_in (unsigned)
// busy       out  1  high in S_SHIFT
//
// BEHAVIOUR
// Reset (async, rst=1): state=S_IDLE; diff=0, b_out=0, out_valid=0, busy=0, in_ready=1;
//   internal shift regs, borrow, bit count=0. Reset mid-operation discards work in flight.
// FSM states: S_IDLE, S_SHIFT, S_DONE. All transitions below require ena=1.
// S_IDLE:  in_ready=1. If in_valid: capture a->sa, b->sb, b_in->br, cnt=0; go to S_SHIFT.
// S_SHIFT: in_ready=0, busy=1. Each cycle:
//   d   = sa[0] ^ sb[0] ^ br
//   br' = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
//   sa>>=1; sb>>=1; diff shifts right with d entering at bit N-1; cnt++.
//   When cnt==N-1 (the Nth bit): go to S_DONE; b_out=br'; out_valid=1.
// S_DONE:  out_valid=1, in_ready=0; diff/b_out held stable.
//   If out_ready: out_valid=0 next cycle; go to S_IDLE.
// Latency: operands captured at edge E; out_valid rises after edge E+N (with ena held high).
// Throughput: one result per N+2 cycles at best (no overlap of accept and drain).
// Output holds: diff is not cleared on return to S_IDLE; the last result stays visible
//   (out_valid=0).
// in_valid while not in S_IDLE is ignored. Inputs a/b/b_in are sampled only at capture.
// ena=0 in any state: nothing changes, including cnt, and in DONE out_ready is ignored.
// Width rules: cnt is $clog2(N+1) bits. With N=1, S_SHIFT lasts exactly one cycle.
// Unsigned wrap: 0 - 1 -> diff=2^N-1, b_out=1.
//
// TESTING
// Reset, then a=8'd100 b=8'd58 b_in=0 -> out_valid 8 cycles after accept; diff=42, b_out=0.
// a=0 b=1 b_in=0 -> diff=8'hFF, b_out=1; a=8'h80 b=8'h7F b_in=1 -> diff=0, b_out=0.
// Hold out_ready=0 for 5 cycles in S_DONE -> diff/out_valid stable; in_valid pulses ignored.
// Toggle ena low for 3 cycles mid-S_SHIFT -> result identical and latency +3.
// Assert rst at bit 4 of an operation -> outputs zeroed immediately (async); next op correct.
// Random sweep, 1000 ops, N=8 and N=1 -> {b_out,diff} == {1'b0,a} - b - b_in (9-bit compare).

Source files
------------

// File: rtl/serial_subtractor_n_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// slave = the subtractor itself, master = whoever feeds and drains it.
interface serial_subtractor_n_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         b_out;

    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, diff, b_out
    );

    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, diff, b_out
    );
endinterface

// File: rtl/serial_subtractor_n.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first,
// through a single full-subtractor cell. Operands in and result out each use a
// valid/ready handshake; accept and drain never overlap.
module serial_subtractor_n #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    output logic                  busy,
    serial_subtractor_n_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     sa_q, sa_d;      // minuend, consumed from bit 0
    logic [N-1:0]     sb_q, sb_d;      // subtrahend, consumed from bit 0
    logic             br_q, br_d;      // running borrow
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     diff_q, diff_d;  // result builds in from the top
    logic             bout_q, bout_d;

    // Single full-subtractor cell on the current LSBs.
    logic dbit, br_nxt;
    assign dbit   = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

    // Next-state logic; with ena low every register keeps its value.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sa_d    = bus.a;
                        sb_d    = bus.b;
                        br_d    = bus.b_in;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sa_d   = sa_q >> 1;
                    sb_d   = sb_q >> 1;
                    br_d   = br_nxt;
                    // Shift form keeps this legal for N == 1 (no reversed slice).
                    diff_d = (diff_q >> 1) | (N'(dbit) << (N - 1));
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        bout_d  = br_nxt;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // diff/b_out are left alone so the last result stays visible.
                    if (bus.out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Handshake and status flags decode directly from the registered state.
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign busy          = (state_q == S_SHIFT);
    assign bus.diff      = diff_q;
    assign bus.b_out     = bout_q;
endmodule

// File: tb/tb_serial_subtractor_n.sv
// Self-checking bench for serial_subtractor_n: fixed vector table, hand-written
// corner sequences (DONE hold, ena stall, async reset mid-op) and random sweeps
// at N=8 and N=1 against an integer-arithmetic reference.
module tb_serial_subtractor_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena8 = 1'b1;
    logic ena1 = 1'b1;
    logic busy8, busy1;

    always #5 clk = ~clk;

    serial_subtractor_n_if #(.N(8)) bus8 ();
    serial_subtractor_n_if #(.N(1)) bus1 ();

    serial_subtractor_n #(.N(8)) dut8 (.clk(clk), .rst(rst), .ena(ena8), .busy(busy8), .bus(bus8));
    serial_subtractor_n #(.N(1)) dut1 (.clk(clk), .rst(rst), .ena(ena1), .busy(busy1), .bus(bus1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: plain signed arithmetic, borrow = result went negative.
    function automatic int ref_sub(input int n, input int a, input int b, input int bin);
        int full;
        full = a - b - bin;
        return ((full < 0) ? (1 << n) : 0) | (full & ((1 << n) - 1));
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec_t;
    vec_t tbl[7];

    // Full transaction on the N=8 instance; lat = edges from capture to out_valid.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output int lat);
        int k;
        k = 0;
        while (!bus8.in_ready && k < 100) begin @(posedge clk); #1; k++; end
        chk("run8_idle_timeout", 32'(bus8.in_ready), 32'd1);
        bus8.a = a; bus8.b = b; bus8.b_in = bin; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!bus8.out_valid) chk("run8_done_timeout", 32'd0, 32'd1);
        d = bus8.diff; bo = bus8.b_out;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic run1(input logic a, input logic b, input logic bin,
                        output logic d, output logic bo, output int lat);
        int k;
        k = 0;
        while (!bus1.in_ready && k < 100) begin @(posedge clk); #1; k++; end
        if (!bus1.in_ready) chk("run1_idle_timeout", 32'd0, 32'd1);
        bus1.a = a; bus1.b = b; bus1.b_in = bin; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!bus1.out_valid) chk("run1_done_timeout", 32'd0, 32'd1);
        d = bus1.diff; bo = bus1.b_out;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d8, ra, rb;
        logic       bo, d1, rbin;
        int         lat, k;

        tbl[0] = '{8'd100, 8'd58,  1'b0, 8'd42,  1'b0};
        tbl[1] = '{8'h00,  8'h01,  1'b0, 8'hFF,  1'b1};
        tbl[2] = '{8'h80,  8'h7F,  1'b1, 8'h00,  1'b0};
        tbl[3] = '{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1};
        tbl[4] = '{8'hFF,  8'h00,  1'b0, 8'hFF,  1'b0};
        tbl[5] = '{8'h00,  8'h00,  1'b1, 8'hFF,  1'b1};
        tbl[6] = '{8'h05,  8'h03,  1'b1, 8'h01,  1'b0};

        bus8.in_valid = 0; bus8.out_ready = 0; bus8.a = 0; bus8.b = 0; bus8.b_in = 0;
        bus1.in_valid = 0; bus1.out_ready = 0; bus1.a = 0; bus1.b = 0; bus1.b_in = 0;

        // Reset values, observed while reset is still asserted.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(bus8.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("rst_busy",      32'(busy8),          32'd0);
        chk("rst_diff",      32'(bus8.diff),      32'd0);
        chk("rst_b_out",     32'(bus8.b_out),     32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fixed vectors: result and latency.
        for (int i = 0; i < 7; i++) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].bin, d8, bo, lat);
            chk("tbl_result", {23'd0, bo, d8}, {23'd0, tbl[i].bo, tbl[i].d});
            chk("tbl_latency", 32'(lat), 32'd8);
        end
        // Result stays visible in IDLE with out_valid low.
        chk("idle_hold_diff",  32'(bus8.diff),      32'(tbl[6].d));
        chk("idle_out_valid",  32'(bus8.out_valid), 32'd0);

        // DONE hold: out_ready low for 5 cycles, in_valid pulses with other data.
        bus8.a = 8'd200; bus8.b = 8'd13; bus8.b_in = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        k = 0;
        while (!bus8.out_valid && k < 50) begin @(posedge clk); #1; k++; end
        chk("hold_latency", 32'(k), 32'd8);
        for (int c = 0; c < 5; c++) begin
            bus8.a = 8'(c * 37); bus8.b = 8'd1; bus8.in_valid = c[0];
            @(posedge clk); #1;
            chk("hold_out_valid", 32'(bus8.out_valid), 32'd1);
            chk("hold_diff",      32'(bus8.diff),      32'd187);
            chk("hold_in_ready",  32'(bus8.in_ready),  32'd0);
        end
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        chk("drain_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("drain_in_ready",  32'(bus8.in_ready),  32'd1);
        chk("drain_diff_kept", 32'(bus8.diff),      32'd187);

        // ena low for 3 cycles mid-shift: same result, latency + 3.
        bus8.a = 8'd77; bus8.b = 8'd33; bus8.b_in = 1'b1; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1; ena8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_busy", 32'(busy8), 32'd1);
        ena8 = 1'b1;
        lat = 6;
        while (!bus8.out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("stall_latency", 32'(lat), 32'd11);
        chk("stall_result", {23'd0, bus8.b_out, bus8.diff}, 32'd43);
        // ena low in DONE: out_ready ignored.
        ena8 = 1'b0; bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_done_held", 32'(bus8.out_valid), 32'd1);
        ena8 = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        chk("stall_done_drain", 32'(bus8.out_valid), 32'd0);

        // Async reset at bit 4 of an operation.
        bus8.a = 8'd200; bus8.b = 8'd13; bus8.b_in = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy8), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_diff",      32'(bus8.diff),      32'd0);
        chk("arst_b_out",     32'(bus8.b_out),     32'd0);
        chk("arst_busy",      32'(busy8),          32'd0);
        chk("arst_out_valid", 32'(bus8.out_valid), 32'd0);
        chk("arst_in_ready",  32'(bus8.in_ready),  32'd1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run8(8'd100, 8'd58, 1'b0, d8, bo, lat);
        chk("post_rst_result", {23'd0, bo, d8}, 32'd42);
        chk("post_rst_latency", 32'(lat), 32'd8);

        // Random sweep, N=8.
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            run8(ra, rb, rbin, d8, bo, lat);
            chk("rand8", {23'd0, bo, d8}, 32'(ref_sub(8, int'(ra), int'(rb), int'(rbin))));
        end

        // Random sweep, N=1 (single-cycle shift phase).
        for (int i = 0; i < 1000; i++) begin
            ra[0] = 1'($urandom); rb[0] = 1'($urandom); rbin = 1'($urandom);
            run1(ra[0], rb[0], rbin, d1, bo, lat);
            chk("rand1", {30'd0, bo, d1}, 32'(ref_sub(1, int'(ra[0]), int'(rb[0]), int'(rbin))));
            if (i < 8) chk("rand1_latency", 32'(lat), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
